// File: rtl/snoop_bus_pkg.sv
// Shared types for the MSI snooping bus arbiter.
// Bus operation encoding and arbiter FSM state codes.
package snoop_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NONE = 2'b11
  } bus_op_t;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t IDLE    = 2'd0;
  localparam bus_state_t SNOOP   = 2'd1;
  localparam bus_state_t L2_WAIT = 2'd2;
  localparam bus_state_t DONE    = 2'd3;

endpackage

// File: rtl/snoop_bus_arbiter_rr.sv
// Combinational round-robin picker.
// Grants the first set req_vec bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_vec,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  // Walk the search order backwards so the earliest candidate wins.
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vec[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin MSI snooping bus between per-core L1s and L2.
// Optional L2 wait timeout: define SNOOP_BUS_TIMEOUT_EN.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES*2-1:0]        op,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  output logic [NUM_CORES-1:0]          grant,
  output logic [NUM_CORES-1:0]          done,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rdata_shared,
  output logic [NUM_CORES-1:0]          err,
  output logic                          snoop_valid,
  output logic [1:0]                    snoop_op,
  output logic [ADDR_W-1:0]             snoop_addr,
  output logic [$clog2(NUM_CORES)-1:0]  snoop_src,
  input  logic [NUM_CORES-1:0]          snoop_hit,
  input  logic [NUM_CORES*DATA_W-1:0]   snoop_data,
  output logic                          l2_req,
  output logic [ADDR_W-1:0]             l2_addr,
  input  logic                          l2_ack,
  input  logic [DATA_W-1:0]             l2_rdata
);

  localparam int IW = $clog2(NUM_CORES);

  bus_state_t          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                shared_q, shared_d;

  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic [1:0]           sel_op;
  logic [ADDR_W-1:0]    sel_addr;
  logic [NUM_CORES-1:0] owner_oh;
  logic [NUM_CORES-1:0] hit_m;
  logic                 peer_hit;
  logic [DATA_W-1:0]    peer_data;
  logic [IW-1:0]        ptr_nxt;
  logic                 tmo;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = req[i] && (op[i*2 +: 2] != BUS_NONE);
    end
  end

  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .req_vec (elig),
    .ptr     (ptr_q),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    sel_op   = BUS_NONE;
    sel_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) begin
        gnt_idx  = IW'(i);
        sel_op   = op[i*2 +: 2];
        sel_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign owner_oh = NUM_CORES'(1) << owner_q;
  assign hit_m    = snoop_hit & ~owner_oh;
  assign ptr_nxt  = (owner_q == IW'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;

  // Lowest-index hitting peer supplies the line.
  always_comb begin
    peer_hit  = 1'b0;
    peer_data = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_m[i]) begin
        peer_hit  = 1'b1;
        peer_data = snoop_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SNOOP_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_d = (state_q == L2_WAIT) ? cnt_q + 1'b1 : '0;
  assign tmo   = (state_q == L2_WAIT) && !l2_ack &&
                 (cnt_q == CW'(TIMEOUT - 1));
  assign err   = tmo ? owner_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign tmo            = 1'b0;
  assign err            = '0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    shared_d = shared_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          owner_d = gnt_idx;
          op_d    = sel_op;
          addr_d  = sel_addr;
          state_d = SNOOP;
        end
      end
      SNOOP: begin
        if (op_q == BUS_UPGR) begin
          rdata_d  = '0;
          shared_d = 1'b0;
          state_d  = DONE;
        end else if (peer_hit) begin
          rdata_d  = peer_data;
          shared_d = 1'b1;
          state_d  = DONE;
        end else begin
          state_d  = L2_WAIT;
        end
      end
      L2_WAIT: begin
        if (l2_ack) begin
          rdata_d  = l2_rdata;
          shared_d = 1'b0;
          state_d  = DONE;
        end else if (tmo) begin
          ptr_d   = ptr_nxt;
          state_d = IDLE;
        end
      end
      DONE: begin
        ptr_d   = ptr_nxt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      op_q     <= BUS_NONE;
      addr_q   <= '0;
      rdata_q  <= '0;
      shared_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      shared_q <= shared_d;
    end
  end

  assign grant        = (state_q != IDLE) ? owner_oh : '0;
  assign done         = (state_q == DONE) ? owner_oh : '0;
  assign rdata        = (state_q == DONE) ? rdata_q : '0;
  assign rdata_shared = (state_q == DONE) && shared_q;
  assign snoop_valid  = (state_q == SNOOP);
  assign snoop_op     = (state_q == SNOOP) ? op_q : BUS_NONE;
  assign snoop_addr   = (state_q == SNOOP) ? addr_q : '0;
  assign snoop_src    = (state_q == SNOOP) ? owner_q : '0;
  assign l2_req       = (state_q == L2_WAIT);
  assign l2_addr      = (state_q == L2_WAIT) ? addr_q : '0;

endmodule
